mod47_stream_ctrl: RTL

//  Sequencer that reduces an arbitrarily long operand modulo 47, fed MSW-first as W-bit words over a valid/ready stream.
//  Per accepted word: acc <= (acc*2^W + word) mod 47, using one shared combinational fold unit.

---
 rtl/mod47_pkg.sv | 24 ++
 rtl/mod47_fold.sv | 35 +++
 rtl/mod47_stream_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mod47_pkg.sv
// Shared types and constants for the streaming mod-47 reducer.
// Holds the fold weight helper so the fold unit scales with its input width.
package mod47_pkg;

  localparam logic [5:0] MOD47 = 6'd47;
  localparam int         REM_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Weight of the k-th 6-bit chunk: 2^(6k) mod 47.
  function automatic int unsigned pow64_mod47(input int unsigned k);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < k; i++) begin
      r = (r * 64) % 47;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod47_fold.sv
// Combinational X mod 47: weighted 6-bit chunk sum, repeated 6-bit narrowing, one final subtract.
// Zero latency; no flow control.
module mod47_fold
  import mod47_pkg::*;
#(
  parameter int IN_W = 30
) (
  input  logic [IN_W-1:0]  i_x,
  output logic [REM_W-1:0] o_r
);

  localparam int NCH   = (IN_W + 5) / 6;
  localparam int PAD_W = NCH * 6;
  localparam int S_W   = 13 + $clog2(NCH + 1);
  // Each narrowing pass shrinks the bound by about 2 bits until it settles below 2*47.
  localparam int N_IT  = S_W / 2 + 2;

  logic [PAD_W-1:0] w_xpad;
  logic [S_W-1:0]   w_sum;

  assign w_xpad = PAD_W'(i_x);

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sum = w_sum + S_W'(w_xpad[k*6 +: 6]) * S_W'(pow64_mod47(k));
    end
    for (int i = 0; i < N_IT; i++) begin
      w_sum = S_W'(w_sum[5:0]) + S_W'(w_sum[S_W-1:6]) * S_W'(pow64_mod47(1));
    end
  end

  assign o_r = REM_W'((w_sum >= S_W'(MOD47)) ? (w_sum - S_W'(MOD47)) : w_sum);

endmodule

// File: rtl/mod47_stream_ctrl.sv
// Streams an MSW-first operand and returns operand mod 47; result registered 1 cycle after the last word.
// in_ready drops while a result waits for out_ready or during flush; one word per clock otherwise.
module mod47_stream_ctrl
  import mod47_pkg::*;
#(
  parameter int W     = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REM_W-1:0] out_rem,
  output logic [CNT_W-1:0] out_words,
  output logic             out_sat
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REM_W-1:0]   r_acc;
  logic [REM_W-1:0]   w_fold;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_in_rdy;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               r_out_valid;
  logic [REM_W-1:0]   r_out_rem;
  logic [CNT_W-1:0]   r_out_words;
  logic               r_out_sat;

  mod47_fold #(
    .IN_W(REM_W + W)
  ) u_fold (
    .i_x({r_acc, in_data}),
    .o_r(w_fold)
  );

  assign w_in_rdy   = rst_n & ~flush & (r_state != DONE);
  assign w_in_fire  = in_valid & w_in_rdy;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  assign in_ready  = w_in_rdy;
  assign out_valid = r_out_valid;
  assign out_rem   = r_out_rem;
  assign out_words = r_out_words;
  assign out_sat   = r_out_sat;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, ACC: begin
        if (w_in_fire) begin
          w_state_nxt = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // acc/cnt are cleared as the final word is captured, so IDLE always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_rem   <= '0;
      r_out_words <= '0;
      r_out_sat   <= 1'b0;
    end else if (flush) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_out_fire) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_acc       <= in_last ? '0 : w_fold;
      r_cnt       <= in_last ? '0 : w_cnt_inc;
      r_out_valid <= in_last;
      if (in_last) begin
        r_out_rem   <= w_fold;
        r_out_words <= w_cnt_inc;
        r_out_sat   <= &w_cnt_inc;
      end
    end
  end

endmodule
